// File: rtl/axis_gen_pkg.sv
// Shared types and helpers for the AXI-Stream pattern generator.
// The final-beat keep mask is expressed per byte lane so any KEEP_W can use it.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  localparam int unsigned DefDataW = 512;
  localparam int unsigned DefKeepW = DefDataW / 8;

  // Bit idx of the final-beat tkeep for a packet of len bytes.
  // A length that fills the last beat exactly yields all ones.
  function automatic logic final_keep_bit(input logic [15:0] len, input int unsigned keep_w,
                                          input int unsigned idx);
    int unsigned r;
    r = 32'(len) % keep_w;
    return (r == 0) || (idx < r);
  endfunction

endpackage

// File: rtl/axis_pattern_gen.sv
// AXI-Stream packet generator: emits pkt_count packets of pkt_len bytes carrying an
// incrementing 32-bit word sequence, with optional idle gaps between packets.
module axis_pattern_gen
  import axis_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              axi_aclk,
  input  logic              axi_reset,
  input  logic              start,
  input  logic [15:0]       pkt_len,
  input  logic [15:0]       pkt_count,
  input  logic [7:0]        gap_cycles,
  input  logic [31:0]       seed,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       beat_total
);

  localparam int unsigned WordsPerBeat = DATA_W / 32;

  state_e              state_q, state_d;
  logic [15:0]         beats_q, beats_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         pkt_idx_q, pkt_idx_d;
  logic [15:0]         beat_idx_q, beat_idx_d;
  logic [7:0]          gap_q, gap_d;
  logic [7:0]          gap_cnt_q, gap_cnt_d;
  logic [31:0]         word_q, word_d;
  logic [KEEP_W-1:0]   last_keep_q, last_keep_d;
  logic [31:0]         beat_total_q, beat_total_d;
  logic                done_q, done_d;

  logic                tvalid_c;
  logic                is_last_beat;
  logic                is_last_pkt;
  logic [31:0]         beats_calc;
  logic [KEEP_W-1:0]   last_keep_calc;
  logic [KEEP_W-1:0]   keep_c;
  logic [DATA_W-1:0]   data_c;

  always_comb begin
    beats_calc = (32'(pkt_len) + KEEP_W - 1) / KEEP_W;
    last_keep_calc = '0;
    for (int b = 0; b < int'(KEEP_W); b++) begin
      last_keep_calc[b] = final_keep_bit(pkt_len, KEEP_W, b);
    end
  end

  assign is_last_beat = (beat_idx_q == beats_q - 16'd1);
  assign is_last_pkt  = (pkt_idx_q == pkt_cnt_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    pkt_cnt_d    = pkt_cnt_q;
    pkt_idx_d    = pkt_idx_q;
    beat_idx_d   = beat_idx_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    word_d       = word_q;
    last_keep_d  = last_keep_q;
    beat_total_d = beat_total_q;
    done_d       = 1'b0;
    tvalid_c     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Empty runs complete immediately without leaving IDLE.
          if (pkt_len == 16'd0 || pkt_count == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d     = StSend;
            beats_d     = 16'(beats_calc);
            pkt_cnt_d   = pkt_count;
            pkt_idx_d   = 16'd0;
            beat_idx_d  = 16'd0;
            gap_d       = gap_cycles;
            word_d      = seed;
            last_keep_d = last_keep_calc;
          end
        end
      end
      StSend: begin
        tvalid_c = 1'b1;
        if (m_axis_tready) begin
          beat_total_d = beat_total_q + 32'd1;
          word_d       = word_q + 32'(WordsPerBeat);
          if (is_last_beat) begin
            beat_idx_d = 16'd0;
            if (is_last_pkt) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              pkt_idx_d = pkt_idx_q + 16'd1;
              if (gap_q != 8'd0) begin
                state_d   = StGap;
                gap_cnt_d = gap_q;
              end
            end
          end else begin
            beat_idx_d = beat_idx_q + 16'd1;
          end
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (gap_cnt_q == 8'd1) state_d = StSend;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    keep_c = is_last_beat ? last_keep_q : '1;
    data_c = '0;
    for (int i = 0; i < int'(WordsPerBeat); i++) begin
      data_c[i*32 +: 32] = word_q + 32'(i);
    end
    for (int b = 0; b < int'(KEEP_W); b++) begin
      if (!keep_c[b]) data_c[b*8 +: 8] = 8'h00;
    end
  end

  always_comb begin
    m_axis_tvalid = tvalid_c;
    m_axis_tlast  = tvalid_c & is_last_beat;
    m_axis_tkeep  = tvalid_c ? keep_c : '0;
    m_axis_tdata  = tvalid_c ? data_c : '0;
    busy          = (state_q != StIdle);
    done          = done_q;
    beat_total    = beat_total_q;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q      <= StIdle;
      beats_q      <= '0;
      pkt_cnt_q    <= '0;
      pkt_idx_q    <= '0;
      beat_idx_q   <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      word_q       <= '0;
      last_keep_q  <= '0;
      beat_total_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      pkt_cnt_q    <= pkt_cnt_d;
      pkt_idx_q    <= pkt_idx_d;
      beat_idx_q   <= beat_idx_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      word_q       <= word_d;
      last_keep_q  <= last_keep_d;
      beat_total_q <= beat_total_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Scoreboard bench for axis_pattern_gen: runs push expected beats, a negedge monitor
// pops and compares on every handshake and checks stall stability.
module tb_axis_pattern_gen;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;

  logic          clk = 1'b0;
  logic          axi_reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   pkt_len = '0;
  logic [15:0]   pkt_count = '0;
  logic [7:0]    gap_cycles = '0;
  logic [31:0]   seed = '0;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          busy;
  logic          done;
  logic [31:0]   beat_total;

  axis_pattern_gen #(
    .DATA_W(DW),
    .KEEP_W(KW)
  ) dut (
    .axi_aclk     (clk),
    .axi_reset    (axi_reset),
    .start        (start),
    .pkt_len      (pkt_len),
    .pkt_count    (pkt_count),
    .gap_cycles   (gap_cycles),
    .seed         (seed),
    .m_axis_tdata (tdata),
    .m_axis_tkeep (tkeep),
    .m_axis_tlast (tlast),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .busy         (busy),
    .done         (done),
    .beat_total   (beat_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    hs_cyc[$];
  int    cyc = 0;
  int    hs_total = 0;
  int    done_cnt = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Expected beats of a run; lkeep is the hand-computed final-beat keep.
  task automatic push_run(input logic [15:0] len, input logic [15:0] cnt,
                          input logic [31:0] sd, input logic [KW-1:0] lkeep);
    int nb = (int'(len) + 63) / 64;
    logic [31:0] w = sd;
    beat_t b;
    for (int p = 0; p < int'(cnt); p++) begin
      for (int k = 0; k < nb; k++) begin
        b.last = (k == nb - 1);
        b.keep = b.last ? lkeep : '1;
        for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = w + 32'(i);
        for (int j = 0; j < 64; j++) if (!b.keep[j]) b.data[j*8 +: 8] = 8'h00;
        exp_q.push_back(b);
        w = w + 32'd16;
      end
    end
  endtask

  // Start is sampled at the second edge; inputs are scrambled afterwards.
  task automatic start_run(input logic [15:0] len, input logic [15:0] cnt,
                           input logic [7:0] gap, input logic [31:0] sd);
    @(posedge clk);
    #1;
    pkt_len = len; pkt_count = cnt; gap_cycles = gap; seed = sd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pkt_len = 16'($urandom); pkt_count = 16'($urandom);
    gap_cycles = 8'($urandom); seed = $urandom;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    bit ok = 1'b0;
    dcyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    chk("done_seen", 512'(ok), 512'(1));
  endtask

  // Monitor: scoreboard pop on handshake, hold check while stalled.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] hold_data;
  logic [KW-1:0] hold_keep;
  logic          hold_last;

  always @(negedge clk) begin
    if (axi_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 512'(tvalid), 512'(1));
        chk("stall_data", tdata, hold_data);
        chk("stall_keep", 512'(tkeep), 512'(hold_keep));
        chk("stall_last", 512'(tlast), 512'(hold_last));
      end
      if (tvalid && tready) begin
        hs_total++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h, want no beat", tdata[63:0]);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", tdata, e.data);
          chk("beat_keep", 512'(tkeep), 512'(e.keep));
          chk("beat_last", 512'(tlast), 512'(e.last));
        end
      end
      prev_stall = tvalid && !tready;
      hold_data = tdata;
      hold_keep = tkeep;
      hold_last = tlast;
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int dcyc;
    int h0;
    int d0;
    logic [31:0] bt0;
    bit seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 512'(tvalid), 512'(0));
    chk("rst_tlast", 512'(tlast), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_beat_total", 512'(beat_total), 512'(0));
    chk("rst_tdata", tdata, 512'(0));
    chk("rst_tkeep", 512'(tkeep), 512'(0));
    @(posedge clk);
    #1 axi_reset = 1'b0;

    // 128 bytes, seed 0: two full beats, done right after the last one.
    hs_cyc.delete();
    bt0 = beat_total;
    push_run(16'd128, 16'd1, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    start_run(16'd128, 16'd1, 8'd0, 32'd0);
    wait_done(50, dcyc);
    chk("r128_beats", 512'(hs_cyc.size()), 512'(2));
    chk("r128_b2b", 512'(hs_cyc[1] - hs_cyc[0]), 512'(1));
    chk("r128_done_lat", 512'(dcyc - hs_cyc[1]), 512'(1));
    chk("r128_busy", 512'(busy), 512'(0));
    chk("r128_total", 512'(beat_total - bt0), 512'(2));

    // 100 bytes: partial final beat, low 36 lanes.
    push_run(16'd100, 16'd1, 32'h1000, 64'h0000_000F_FFFF_FFFF);
    start_run(16'd100, 16'd1, 8'd0, 32'h1000);
    wait_done(50, dcyc);

    // Three single-beat packets, no gap: one beat per cycle across packets.
    hs_cyc.delete();
    push_run(16'd64, 16'd3, 32'hABCD_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    start_run(16'd64, 16'd3, 8'd0, 32'hABCD_0000);
    wait_done(50, dcyc);
    chk("nogap_span", 512'(hs_cyc[2] - hs_cyc[0]), 512'(2));

    // Gap of 2, with a start pulse issued mid-run that must be ignored.
    hs_cyc.delete();
    h0 = hs_total;
    push_run(16'd64, 16'd3, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    start_run(16'd64, 16'd3, 8'd2, 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hs_total > h0) break;
    end
    start_run(16'd128, 16'd5, 8'd0, 32'd999);
    wait_done(100, dcyc);
    chk("gap_spacing0", 512'(hs_cyc[1] - hs_cyc[0]), 512'(3));
    chk("gap_spacing1", 512'(hs_cyc[2] - hs_cyc[1]), 512'(3));
    h0 = hs_total;
    repeat (8) @(negedge clk);
    chk("midrun_ignored", 512'(hs_total - h0), 512'(0));
    chk("midrun_busy", 512'(busy), 512'(0));
    chk("midrun_queue", 512'(exp_q.size()), 512'(0));

    // Random backpressure, 4 x 1000 bytes, seed near wrap.
    bt0 = beat_total;
    h0 = hs_total;
    push_run(16'd1000, 16'd4, 32'hFFFF_FFF0, 64'h0000_00FF_FFFF_FFFF);
    start_run(16'd1000, 16'd4, 8'd1, 32'hFFFF_FFF0);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk);
      #1 tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("bp_done_seen", 512'(seen), 512'(1));
    @(posedge clk);
    #1 tready = 1'b1;
    chk("bp_total", 512'(beat_total - bt0), 512'(64));
    chk("bp_beats", 512'(hs_total - h0), 512'(64));
    chk("bp_queue", 512'(exp_q.size()), 512'(0));

    // Empty runs: done pulse one cycle after start, no beats.
    h0 = hs_total;
    start_run(16'd0, 16'd3, 8'd0, 32'd7);
    @(negedge clk);
    chk("len0_done", 512'(done), 512'(1));
    chk("len0_tvalid", 512'(tvalid), 512'(0));
    chk("len0_busy", 512'(busy), 512'(0));
    @(negedge clk);
    chk("len0_done_pulse", 512'(done), 512'(0));
    start_run(16'd64, 16'd0, 8'd0, 32'd7);
    @(negedge clk);
    chk("cnt0_done", 512'(done), 512'(1));
    @(negedge clk);
    chk("cnt0_nobeats", 512'(hs_total - h0), 512'(0));

    // Reset mid-packet: run abandoned, counter cleared, no done.
    push_run(16'd1000, 16'd1, 32'd100, 64'h0000_00FF_FFFF_FFFF);
    h0 = hs_total;
    start_run(16'd1000, 16'd1, 8'd0, 32'd100);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hs_total >= h0 + 3) break;
    end
    d0 = done_cnt;
    @(posedge clk);
    #1 axi_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tvalid", 512'(tvalid), 512'(0));
    chk("mid_rst_total", 512'(beat_total), 512'(0));
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_done", 512'(done), 512'(0));
    @(posedge clk);
    #1 axi_reset = 1'b0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    chk("mid_rst_no_done", 512'(done_cnt - d0), 512'(0));
    chk("mid_rst_idle", 512'(tvalid), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
